// File: rtl/interrupt_sequencer_pkg.sv
// Shared constants, state/source encodings and vector lookup for the interrupt sequencer.
package interrupt_sequencer_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int REG_WIDTH  = 8;

    localparam logic [ADDR_WIDTH-1:0] VEC_NMI    = 16'hFFFA;
    localparam logic [ADDR_WIDTH-1:0] VEC_RST    = 16'hFFFC;
    localparam logic [ADDR_WIDTH-1:0] VEC_IRQ    = 16'hFFFE;
    localparam logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        IDLE     = 3'd1,
        PUSH_PCH = 3'd2,
        PUSH_PCL = 3'd3,
        PUSH_P   = 3'd4,
        VEC_LO   = 3'd5,
        VEC_HI   = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        SRC_RST = 2'd0,
        SRC_NMI = 2'd1,
        SRC_IRQ = 2'd2,
        SRC_BRK = 2'd3
    } src_e;

    // IRQ and BRK share one vector; BRK is told apart by the pushed B bit.
    function automatic logic [ADDR_WIDTH-1:0] vec_base(input src_e s);
        case (s)
            SRC_NMI: vec_base = VEC_NMI;
            SRC_RST: vec_base = VEC_RST;
            default: vec_base = VEC_IRQ;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Decoder, register-file and memory-port signals of the interrupt sequencer.
interface interrupt_sequencer_if;
    import interrupt_sequencer_pkg::*;

    logic                  nmi_n;
    logic                  irq_n;
    logic                  brk_req;
    logic                  instr_boundary;
    logic                  irq_disable;
    logic [ADDR_WIDTH-1:0] pc_in;
    logic [REG_WIDTH-1:0]  sp_in;
    logic [REG_WIDTH-1:0]  status_in;
    logic [REG_WIDTH-1:0]  data_in;

    logic                  busy;
    logic [ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]  data_out;
    logic                  mem_we;
    logic [REG_WIDTH-1:0]  sp_out;
    logic                  sp_we;
    logic [ADDR_WIDTH-1:0] pc_out;
    logic                  pc_we;
    logic                  set_i;
    logic                  done;
    logic [1:0]            src;

    modport master (
        input  nmi_n, irq_n, brk_req, instr_boundary, irq_disable,
               pc_in, sp_in, status_in, data_in,
        output busy, addr, data_out, mem_we, sp_out, sp_we,
               pc_out, pc_we, set_i, done, src
    );

    modport slave (
        output nmi_n, irq_n, brk_req, instr_boundary, irq_disable,
               pc_in, sp_in, status_in, data_in,
        input  busy, addr, data_out, mem_we, sp_out, sp_we,
               pc_out, pc_we, set_i, done, src
    );

endinterface

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// NMI falling-edge detector with a pending latch that survives until the NMI vector is fetched.
module nmi_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic nmi_n,
    input  logic clear,
    output logic pending,
    output logic req
);

    logic nmi_q;
    logic fall;

    // Previous level starts low so a line held low through reset is not an edge.
    assign fall = nmi_q & ~nmi_n;
    assign req  = pending | fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nmi_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            nmi_q   <= nmi_n;
            pending <= fall | (pending & ~clear);
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502-style RST/NMI/IRQ/BRK sequencer: pushes PC and P, fetches the vector, loads PC.
// Optional INTSEQ_NMI_HIJACK_EN lets a pending NMI take over the vector fetch of IRQ/BRK.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    interrupt_sequencer_if.master bus
);

`ifdef INTSEQ_NMI_HIJACK_EN
    localparam bit HIJACK_EN = 1'b1;
`else
    localparam bit HIJACK_EN = 1'b0;
`endif

    seq_state_e           state, state_nxt;
    src_e                 src_q, src_nxt, vec_src;
    logic [REG_WIDTH-1:0] sp_q, sp_nxt, lo_q, lo_nxt;
    logic                 nmi_pending, nmi_req, nmi_clear, hijack;

    nmi_edge_detect u_nmi (
        .clk     (clk),
        .reset   (reset),
        .nmi_n   (bus.nmi_n),
        .clear   (nmi_clear),
        .pending (nmi_pending),
        .req     (nmi_req)
    );

    assign hijack  = HIJACK_EN && nmi_pending && (src_q == SRC_IRQ || src_q == SRC_BRK);
    assign bus.src = src_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RST_HOLD;
            src_q <= SRC_RST;
            sp_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_nxt;
            src_q <= src_nxt;
            sp_q  <= sp_nxt;
            lo_q  <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        src_nxt        = src_q;
        sp_nxt         = sp_q;
        lo_nxt         = lo_q;
        vec_src        = src_q;
        nmi_clear      = 1'b0;
        bus.busy       = 1'b1;
        bus.addr       = '0;
        bus.data_out   = '0;
        bus.mem_we     = 1'b0;
        bus.sp_out     = '0;
        bus.sp_we      = 1'b0;
        bus.pc_out     = '0;
        bus.pc_we      = 1'b0;
        bus.set_i      = 1'b0;
        bus.done       = 1'b0;

        case (state)
            RST_HOLD: begin
                state_nxt = PUSH_PCH;
                src_nxt   = SRC_RST;
                sp_nxt    = bus.sp_in;
            end
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.instr_boundary) begin
                    if (nmi_req)           src_nxt = SRC_NMI;
                    else if (bus.brk_req)  src_nxt = SRC_BRK;
                    else                   src_nxt = SRC_IRQ;
                    if (nmi_req || bus.brk_req || (!bus.irq_n && !bus.irq_disable)) begin
                        state_nxt = PUSH_PCH;
                        sp_nxt    = bus.sp_in;
                    end else begin
                        src_nxt = src_q;
                    end
                end
            end
            PUSH_PCH, PUSH_PCL, PUSH_P: begin
                // Reset walks the stack pointer like a real push but never writes memory.
                bus.addr   = STACK_BASE | {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, sp_q};
                bus.sp_out = sp_q - 1'b1;
                bus.sp_we  = 1'b1;
                bus.mem_we = (src_q != SRC_RST);
                sp_nxt     = sp_q - 1'b1;
                case (state)
                    PUSH_PCH: begin
                        bus.data_out = bus.pc_in[ADDR_WIDTH-1:REG_WIDTH];
                        state_nxt    = PUSH_PCL;
                    end
                    PUSH_PCL: begin
                        bus.data_out = bus.pc_in[REG_WIDTH-1:0];
                        state_nxt    = PUSH_P;
                    end
                    default: begin
                        bus.data_out = (bus.status_in & 8'hCF) | 8'h20 |
                                       ((src_q == SRC_BRK) ? 8'h10 : 8'h00);
                        state_nxt    = VEC_LO;
                    end
                endcase
            end
            VEC_LO: begin
                vec_src   = hijack ? SRC_NMI : src_q;
                bus.addr  = vec_base(vec_src);
                bus.set_i = 1'b1;
                lo_nxt    = bus.data_in;
                src_nxt   = vec_src;
                nmi_clear = (vec_src == SRC_NMI);
                state_nxt = VEC_HI;
            end
            VEC_HI: begin
                bus.addr   = vec_base(src_q) + 16'd1;
                bus.pc_out = {bus.data_in, lo_q};
                bus.pc_we  = 1'b1;
                bus.done   = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = RST_HOLD;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed + randomized bench for interrupt_sequencer; expected bus traffic comes from a sequence-level model.
module tb_interrupt_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    interrupt_sequencer_if bus();

    interrupt_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    assign bus.data_in = mem[bus.addr];

    // Observed traffic, appended only; each scenario remembers where it started.
    logic [23:0] wr_q[$];
    logic [7:0]  spw_q[$];
    logic [15:0] vec_q[$];
    logic [15:0] pcw_q[$];
    logic [1:0]  done_q[$];
    int          busy_cnt = 0;
    int          wb, sb, vb, pb, db, bb;
    int          n_cmp = 0;
    int          n_fail = 0;

    always @(negedge clk) begin
        if (bus.mem_we) wr_q.push_back({bus.addr, bus.data_out});
        if (bus.sp_we)  spw_q.push_back(bus.sp_out);
        if (bus.set_i)  vec_q.push_back(bus.addr);
        if (bus.pc_we)  pcw_q.push_back(bus.pc_out);
        if (bus.done)   done_q.push_back(bus.src);
        if (bus.busy)   busy_cnt++;
    end

    function automatic logic [15:0] vec_of(input logic [1:0] s);
        case (s)
            2'd0:    vec_of = 16'hFFFC;
            2'd1:    vec_of = 16'hFFFA;
            default: vec_of = 16'hFFFE;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        wb = wr_q.size();  sb = spw_q.size(); vb = vec_q.size();
        pb = pcw_q.size(); db = done_q.size(); bb = busy_cnt;
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (done_q.size() == db && i < 40) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk({tag, ":timeout"}, 32'(done_q.size() != db), 1);
        cyc();
    endtask

    // One boundary cycle with the given request lines, then requests are withdrawn.
    task automatic launch(input bit n, input bit b, input bit i, input bit d);
        clear_obs();
        bus.instr_boundary = 1'b1;
        if (n) bus.nmi_n = 1'b0;
        bus.brk_req     = b;
        bus.irq_n       = ~i;
        bus.irq_disable = d;
        cyc();
        bus.instr_boundary = 1'b0;
        bus.brk_req        = 1'b0;
        bus.irq_n          = 1'b1;
    endtask

    // push_src decides the stacked bytes, vsrc the vector and the reported source.
    task automatic check_seq(input string tag, input logic [1:0] push_src, input logic [1:0] vsrc,
                             input logic [15:0] pc, input logic [7:0] sp, input logic [7:0] p);
        logic [23:0] ew [3];
        logic [7:0]  es;
        logic [7:0]  pp;
        logic [15:0] v;
        v = vec_of(vsrc);
        pp = p;
        pp[5] = 1'b1;
        pp[4] = (push_src == 2'd3);
        ew[0] = {8'h01, sp, pc[15:8]};
        ew[1] = {8'h01, sp - 8'd1, pc[7:0]};
        ew[2] = {8'h01, sp - 8'd2, pp};
        chk({tag, ":ndone"}, done_q.size() - db, 1);
        if (done_q.size() > db) chk({tag, ":src"}, done_q[db], vsrc);
        chk({tag, ":nsp"}, spw_q.size() - sb, 3);
        es = sp;
        for (int i = 0; i < 3 && sb + i < spw_q.size(); i++) begin
            es = es - 8'd1;
            chk({tag, ":sp"}, spw_q[sb+i], es);
        end
        if (push_src == 2'd0) begin
            chk({tag, ":nwr"}, wr_q.size() - wb, 0);
        end else begin
            chk({tag, ":nwr"}, wr_q.size() - wb, 3);
            for (int i = 0; i < 3 && wb + i < wr_q.size(); i++)
                chk({tag, ":wr"}, wr_q[wb+i], ew[i]);
        end
        chk({tag, ":nvec"}, vec_q.size() - vb, 1);
        if (vec_q.size() > vb) chk({tag, ":vec"}, vec_q[vb], v);
        chk({tag, ":npc"}, pcw_q.size() - pb, 1);
        if (pcw_q.size() > pb) chk({tag, ":pc"}, pcw_q[pb], {mem[v + 16'd1], mem[v]});
    endtask

    task automatic run_case(input string tag, input bit n, input bit b, input bit i, input bit d,
                            input logic [15:0] pc, input logic [7:0] sp, input logic [7:0] p);
        logic [1:0] es;
        bit take;
        take = n || b || (i && !d);
        es   = n ? 2'd1 : (b ? 2'd3 : 2'd2);
        bus.pc_in     = pc;
        bus.sp_in     = sp;
        bus.status_in = p;
        launch(n, b, i, d);
        bus.nmi_n = 1'b1;
        if (take) begin
            wait_done(tag);
            check_seq(tag, es, es, pc, sp, p);
            chk({tag, ":busy_len"}, busy_cnt - bb, 5);
        end else begin
            chk({tag, ":stay_idle"}, bus.busy, 0);
            repeat (3) cyc();
            chk({tag, ":nodone"}, done_q.size() - db, 0);
        end
        chk({tag, ":idle"}, bus.busy, 0);
    endtask

    initial begin
        bus.nmi_n = 1'b1; bus.irq_n = 1'b1; bus.brk_req = 1'b0; bus.instr_boundary = 1'b0;
        bus.irq_disable = 1'b0; bus.pc_in = '0; bus.sp_in = 8'h00; bus.status_in = '0;
        mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
        mem[16'hFFFA] = 8'($urandom); mem[16'hFFFB] = 8'($urandom);
        mem[16'hFFFE] = 8'($urandom); mem[16'hFFFF] = 8'($urandom);

        // Reset state and the reset sequence
        repeat (2) cyc();
        chk("rst_busy", bus.busy, 1);
        chk("rst_strobes", {bus.mem_we, bus.sp_we, bus.pc_we, bus.set_i, bus.done}, 0);
        chk("rst_outs", {bus.addr, bus.data_out, bus.sp_out}, 0);
        chk("rst_pc_src", {bus.pc_out, bus.src}, 0);
        clear_obs();
        reset = 1'b0;
        wait_done("rst");
        check_seq("rst", 2'd0, 2'd0, 16'h0000, 8'h00, 8'h00);
        if (pcw_q.size() > pb) chk("rst_pc1234", pcw_q[pb], 16'h1234);
        chk("rst_idle", bus.busy, 0);

        // IRQ, masked IRQ, BRK
        run_case("irq", 0, 0, 1, 0, 16'hC012, 8'hFD, 8'h20);
        run_case("irq_masked", 0, 0, 1, 1, 16'hC012, 8'hFD, 8'h20);
        run_case("brk", 0, 1, 0, 0, 16'h4567, 8'h80, 8'h20);
        run_case("sp_wrap", 0, 0, 1, 0, 16'h2233, 8'h01, 8'hFF);

        // Simultaneous NMI edge and BRK; BRK needs to be requested again
        run_case("nmi_brk", 1, 1, 0, 0, 16'h1357, 8'hF0, 8'h04);
        run_case("brk_dropped", 0, 0, 0, 0, 16'h1357, 8'hF0, 8'h04);
        run_case("brk_again", 0, 1, 0, 0, 16'h1357, 8'hF0, 8'h04);

        // NMI edge while an IRQ sequence is pushing PCL
        bus.pc_in = 16'h8001; bus.sp_in = 8'hE0; bus.status_in = 8'h81;
        launch(0, 0, 1, 0);
        cyc();
        bus.nmi_n = 1'b0;
        wait_done("irq_nmi");
        bus.nmi_n = 1'b1;
`ifdef INTSEQ_NMI_HIJACK_EN
        check_seq("irq_nmi", 2'd2, 2'd1, 16'h8001, 8'hE0, 8'h81);
        launch(0, 0, 0, 0);
        chk("no_second_nmi", bus.busy, 0);
        repeat (3) cyc();
        chk("no_second_nmi_done", done_q.size() - db, 0);
`else
        check_seq("irq_nmi", 2'd2, 2'd2, 16'h8001, 8'hE0, 8'h81);
        launch(0, 0, 0, 0);
        wait_done("nmi_late");
        check_seq("nmi_late", 2'd1, 2'd1, 16'h8001, 8'hE0, 8'h81);
`endif

        // Randomized requests against the priority model
        for (int k = 0; k < 12; k++) begin
            mem[16'hFFFA] = 8'($urandom); mem[16'hFFFB] = 8'($urandom);
            mem[16'hFFFE] = 8'($urandom); mem[16'hFFFF] = 8'($urandom);
            run_case("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     16'($urandom), 8'($urandom), 8'($urandom));
        end

        // Reset in the middle of an IRQ sequence
        bus.pc_in = 16'hBEEF; bus.sp_in = 8'h40; bus.status_in = 8'h00;
        launch(0, 0, 1, 0);
        repeat (3) cyc();
        reset = 1'b1;
        #1;
        chk("mid_busy", bus.busy, 1);
        chk("mid_quiet", {bus.addr, bus.set_i, bus.pc_we, bus.mem_we}, 0);
        repeat (2) cyc();
        chk("mid_no_pc", pcw_q.size() - pb, 0);
        chk("mid_no_done", done_q.size() - db, 0);
        mem[16'hFFFC] = 8'($urandom); mem[16'hFFFD] = 8'($urandom);
        bus.sp_in = 8'($urandom);
        clear_obs();
        reset = 1'b0;
        wait_done("mid_rst");
        check_seq("mid_rst", 2'd0, 2'd0, 16'hBEEF, bus.sp_in, 8'h00);
        chk("mid_rst_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: nmi_n  in  1  NMI line; a falling edge requests NMI. irq_n  in  1  IRQ line; level-sensitive, active-low.
REQ-004 SHALL have ports: brk_req  in  1  decoder BRK request. instr_boundary  in  1  decoder instruction_done, the sample point for requests.
REQ-005 SHALL have ports: irq_disable  in  1  status I flag. pc_in  in  `ADDR_WIDTH  return address. sp_in  in  `REG_WIDTH  stack pointer. status_in  in  `REG_WIDTH  P register.
REQ-006 SHALL have ports: data_in  in  `REG_WIDTH  memory read data, valid in the same cycle as addr.
REQ-007 SHALL have ports: busy  out  1  sequence active, fetcher stalled. addr  out  `ADDR_WIDTH  memory address. data_out  out  `REG_WIDTH  write data. mem_we  out  1  memory write strobe.
REQ-008 SHALL have ports: sp_out  out  `REG_WIDTH. sp_we  out  1. pc_out  out  `ADDR_WIDTH. pc_we  out  1. set_i  out  1  set the I flag. done  out  1  one-cycle completion pulse. src  out  2  source code (0 RST, 1 NMI, 2 IRQ, 3 BRK).

Function
REQ-009 SHALL implement the states RST_HOLD, IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO and VEC_HI, spending one clk per state.
REQ-010 SHALL, in IDLE with instr_boundary=1, arbitrate with priority NMI-pending > brk_req > (irq_n=0 and irq_disable=0), latch src, and enter PUSH_PCH on the next edge; with no request it stays in IDLE.
REQ-011 SHALL latch a falling edge of nmi_n into nmi_pending, which holds until the cycle in which the NMI vector is read in VEC_LO clears it.
REQ-012 SHALL, in the PUSH states, drive addr = 16'h0100 | current SP, and assert sp_we with sp_out = SP-1 (8-bit wrap, 8'h00 -> 8'hFF); the current SP is sp_in at entry and is tracked internally afterwards.
REQ-013 SHALL drive data_out as follows: PUSH_PCH = pc_in[15:8]; PUSH_PCL = pc_in[7:0]; PUSH_P = status_in with bit5=1 and bit4=1 only for BRK.
REQ-014 SHALL assert mem_we in the PUSH states for NMI, IRQ and BRK, and hold it at 0 for RST, which still decrements SP.
REQ-015 SHALL, in VEC_LO, drive addr = the vector base (NMI FFFA, RST FFFC, IRQ/BRK FFFE), latch data_in into the low byte, and assert set_i.
REQ-016 SHALL, in VEC_HI, drive addr = the vector base + 1, and assert pc_we with pc_out = {data_in, low byte}, done=1 and src valid, then return to IDLE.
REQ-017 SHALL hold busy=1 in every state except IDLE; the sequence is 5 cycles from PUSH_PCH to VEC_HI inclusive.
REQ-018 SHALL ignore requests and boundaries while busy; an IRQ that is deasserted before the next boundary is lost, while an NMI edge is never lost.
REQ-019 SHALL hold mem_we, sp_we, pc_we, set_i and done at 0 outside the states named above.

Reset
REQ-020 SHALL, while reset=1, force state=RST_HOLD, busy=1, all strobes=0, addr=0, data_out=0, sp_out=0, pc_out=0, src=0 and nmi_pending=0.
REQ-021 SHALL, on the first clk edge after reset falls, enter PUSH_PCH with src=RST regardless of instr_boundary.
REQ-022 SHALL, when reset asserts mid-sequence, abort the sequence immediately with no partial PC write, and restart as an RST sequence.

Configuration
REQ-023 SHALL support the macro INTSEQ_NMI_HIJACK_EN: when it is defined, nmi_pending sampled in VEC_LO of an IRQ or BRK sequence redirects the vector to FFFA, sets src=NMI and clears nmi_pending, while the pushed B bit is unchanged; when it is undefined, the vector follows the latched src and the NMI waits for the next boundary.

Structure
REQ-024 SHALL take the constants `VEC_NMI, `VEC_RST, `VEC_IRQ, `STACK_BASE, the state encodings and the src encodings from PKG/pkg.v, alongside `ADDR_WIDTH and `REG_WIDTH.
REQ-025 SHALL place the NMI falling-edge detector and the pending latch in the sub-module nmi_edge_detect.

Verification
REQ-026 SHALL verify reset release with sp_in=00 and memory FFFC=34, FFFD=12 -> no mem_we, SP writes FF, FE, FD, pc_we with 1234, done with src=0.
REQ-027 SHALL verify IRQ with irq_n=0, I=0, boundary, pc_in=C012, sp_in=FD and P=20 -> writes 01FD=C0, 01FC=12, 01FB=20, vector FFFE read, set_i asserted.
REQ-028 SHALL verify IRQ with irq_n=0 and I=1 at the boundary -> stays IDLE with busy=0.
REQ-029 SHALL verify BRK with P=20 -> pushed P=30, src=3, vector FFFE.
REQ-030 SHALL verify a simultaneous NMI edge and brk_req -> NMI serviced first, and BRK serviced only if the decoder reasserts it at the next boundary.
REQ-031 SHALL verify an NMI edge during PUSH_PCL of an IRQ -> with the macro, vector FFFA and no second NMI; without it, vector FFFE, then an NMI sequence at the next boundary.
